// File: rtl/muldiv_seq_ctrl.sv
// Sequencer that borrows the shared 32-bit ALU to run unsigned shift-add multiply
// and restoring divide, one iteration per cycle, with results held in HI/LO.
module muldiv_seq_ctrl #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_r_i,
  input  logic        alu_cout_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        dbz_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] m_q, m_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic [31:0] shift_s;
  logic        quot_bit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    m_d        = m_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    dbz_d      = dbz_q;
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_ctrl_o = ALU_ADD;
    // A set hi[31] means the 33-bit partial remainder already exceeds the divisor.
    shift_s    = {hi_q[30:0], lo_q[31]};
    quot_bit   = hi_q[31] | alu_cout_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          dbz_d = 1'b0;
          cnt_d = '0;
          if (op_i && (b_i == 32'd0)) begin
            hi_d    = a_i;
            lo_d    = 32'hFFFF_FFFF;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            m_d     = op_i ? b_i : a_i;
            hi_d    = '0;
            lo_d    = op_i ? a_i : b_i;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
        alu_b_o = m_q;
        if (!op_q) begin
          alu_a_o    = hi_q;
          alu_ctrl_o = ALU_ADD;
          if (lo_q[0]) {hi_d, lo_d} = {alu_cout_i, alu_r_i, lo_q[31:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end else begin
          alu_a_o    = shift_s;
          alu_ctrl_o = ALU_SUB;
          hi_d       = quot_bit ? alu_r_i : shift_s;
          lo_d       = {lo_q[30:0], quot_bit};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign dbz_o  = dbz_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: provides a behavioural ALU, a cycle-level reference
// model driven by plain arithmetic, directed corner cases and randomized operations.
module tb_muldiv_seq_ctrl;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] aluA, aluB, aluR;
  logic [3:0]  aluCtrl;
  logic        aluCout;
  logic [31:0] hi, lo;
  logic        busy, done, dbz;
  logic [32:0] aluSum;

  int nVectors = 0;
  int nMiscompares = 0;
  logic checkEn = 1'b0;

  // Reference model state: what the outputs must be in the current cycle.
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic        expDbz  = 1'b0;
  logic [31:0] expHi   = '0;
  logic [31:0] expLo   = '0;
  logic        expOp   = 1'b0;
  logic [31:0] expAluB = '0;
  logic [31:0] pendHi  = '0;
  logic [31:0] pendLo  = '0;
  logic [63:0] prod;
  int          runLeft = 0;

  muldiv_seq_ctrl #(.ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .alu_a_o    (aluA),
    .alu_b_o    (aluB),
    .alu_ctrl_o (aluCtrl),
    .alu_r_i    (aluR),
    .alu_cout_i (aluCout),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy),
    .done_o     (done),
    .dbz_o      (dbz)
  );

  // Shared ALU stand-in: bit 2 of the control code inverts b and supplies carry-in.
  assign aluSum  = {1'b0, aluA} + {1'b0, (aluCtrl[2] ? ~aluB : aluB)} + {32'd0, aluCtrl[2]};
  assign aluR    = aluSum[31:0];
  assign aluCout = aluSum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-level model: tracks acceptance, 32-cycle run window and final results.
  always @(posedge clk) begin
    if (rst) begin
      expBusy = 1'b0; expDone = 1'b0; expDbz = 1'b0;
      expHi = '0; expLo = '0; runLeft = 0;
    end else if (!expBusy) begin
      if (start) begin
        if (op && (b == 32'd0)) begin
          expHi = a; expLo = 32'hFFFF_FFFF; expDbz = 1'b1;
          expBusy = 1'b1; expDone = 1'b1; runLeft = 0;
        end else begin
          if (!op) begin
            prod   = {32'd0, a} * {32'd0, b};
            pendHi = prod[63:32];
            pendLo = prod[31:0];
          end else begin
            pendLo = a / b;
            pendHi = a % b;
          end
          expOp = op; expAluB = op ? b : a;
          expDbz = 1'b0; expBusy = 1'b1; expDone = 1'b0; runLeft = 32;
        end
      end
    end else if (expDone) begin
      expBusy = 1'b0; expDone = 1'b0;
    end else begin
      runLeft--;
      if (runLeft == 0) begin
        expDone = 1'b1; expHi = pendHi; expLo = pendLo;
      end
    end
  end

  // Every-cycle comparison against the model; HI/LO are intermediate while running.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("done", 64'(done), 64'(expDone));
      checkOutput("dbz", 64'(dbz), 64'(expDbz));
      if (!expBusy || expDone) begin
        checkOutput("hi", 64'(hi), 64'(expHi));
        checkOutput("lo", 64'(lo), 64'(expLo));
        checkOutput("aluA_idle", 64'(aluA), 64'd0);
        checkOutput("aluB_idle", 64'(aluB), 64'd0);
        checkOutput("aluCtrl_idle", 64'(aluCtrl), 64'(ALU_ADD));
      end else begin
        checkOutput("aluCtrl_run", 64'(aluCtrl), 64'(expOp ? ALU_SUB : ALU_ADD));
        checkOutput("aluB_run", 64'(aluB), 64'(expAluB));
      end
    end
  end

  task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y, input int expLat,
                       input logic [31:0] hiRef, input logic [31:0] loRef, input logic dbzRef, input string tag);
    int cyc;
    applyStimulus(o, x, y);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(hiRef));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(loRef));
    checkOutput({tag, "_dbz"}, 64'(dbz), 64'(dbzRef));
  endtask

  initial begin
    int cyc;
    logic        ro;
    logic [31:0] rx, ry;
    int          sel;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #2 checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_aluCtrl", 64'(aluCtrl), 64'(ALU_ADD));
    @(posedge clk); #2 rst = 1'b0;

    runOp(1'b0, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0, "mul7x6");
    runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "mulMax");
    runOp(1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, "div100by7");
    runOp(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'h7FFF_FFFE, 32'd1, 1'b0, "divHiBit");
    runOp(1'b1, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, "divZero");
    @(negedge clk);
    checkOutput("divZero_busyCycle2", 64'(busy), 64'd0);

    // Start pulses in cycles 5 and 33 must be ignored; the one in cycle 34 is taken.
    applyStimulus(1'b0, 32'd1234, 32'd5678);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd3;
    @(posedge clk); #2 start = 1'b0;
    repeat (27) @(posedge clk);
    #2 start = 1'b1; op = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    checkOutput("ignore_done33", 64'(done), 64'd1);
    checkOutput("ignore_lo", 64'(lo), 64'd7006652);
    checkOutput("ignore_hi", 64'(hi), 64'd0);
    @(posedge clk); #2 op = 1'b0; a = 32'd9; b = 32'd11;
    @(posedge clk); #2 start = 1'b0;
    waitDone(cyc);
    checkOutput("accept34_latency", 64'(cyc), 64'd33);
    checkOutput("accept34_lo", 64'(lo), 64'd99);

    // Reset in cycle 10 of a divide aborts it.
    applyStimulus(1'b1, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    checkOutput("abort_aluCtrl", 64'(aluCtrl), 64'(ALU_ADD));
    repeat (30) @(posedge clk);
    runOp(1'b0, 32'd9, 32'd9, 33, 32'd0, 32'd81, 1'b0, "mul9x9");

    for (int n = 0; n < 40; n++) begin
      ro  = 1'($urandom_range(0, 1));
      rx  = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      ry = 32'd0;
      else if (sel == 1) ry = $urandom_range(1, 15);
      else               ry = $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(ro, rx, ry);
      waitDone(cyc);
      checkOutput("rnd_latency", 64'(cyc), 64'((ro && (ry == 32'd0)) ? 1 : 33));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
